// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// seg_scan_driver
//   Multiplexed hex display driver. One digit is lit at a time for SCAN_DIV
//   cycles; the scan walks digit 0 up to DIGITS-1 and wraps. New values are
//   staged in a pending buffer and only become visible at the frame wrap, so
//   a single frame never mixes old and new digits.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low blanks the display and freezes the scan
//   num         hex value, nibble k drives digit k (digit 0 least significant)
//   dp          decimal point per digit
//   lz_blank    leading-zero suppression enable
//   load        one-cycle strobe capturing num/dp/lz_blank
//   o_seg       segment bus {dp,g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   o_an        digit select, one-hot when lit, polarity set by ACTIVE_LOW
//   frame_done  one-cycle pulse after the scan wraps back to digit 0
module seg_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   num,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  lz_blank,
   input  logic                  load,
   output logic [7:0]            o_seg,
   output logic [DIGITS-1:0]     o_an,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] pnd_num;
   logic [DIGITS-1:0]   pnd_dp;
   logic                pnd_lz;
   logic                pnd_valid;

   logic [4*DIGITS-1:0] act_num;
   logic [DIGITS-1:0]   act_dp;
   logic                act_lz;

   logic [PSC_W-1:0]    psc;
   logic [IDX_W-1:0]    idx;

   logic [7:0]          seg_log;
   logic [DIGITS-1:0]   an_log;

   logic                step;
   logic                boundary;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                upper_nz;
   logic                suppress;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign step     = en && (psc == PSC_LAST);
   assign boundary = step && (idx == IDX_LAST);

   // Select the lit digit and decide whether it is a leading zero: it is
   // suppressed when no nibble at or above it is non-zero (digit 0 never).
   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      upper_nz = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
         if (j == int'(idx)) begin
            cur_nib = act_num[4*j +: 4];
            cur_dp  = act_dp[j];
         end
         if ((j >= int'(idx)) && (act_num[4*j +: 4] != 4'h0)) begin
            upper_nz = 1'b1;
         end
      end
      suppress = act_lz && (idx != '0) && !upper_nz;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pnd_num    <= '0;
         pnd_dp     <= '0;
         pnd_lz     <= 1'b0;
         pnd_valid  <= 1'b0;
         act_num    <= '0;
         act_dp     <= '0;
         act_lz     <= 1'b0;
         psc        <= '0;
         idx        <= '0;
         seg_log    <= '0;
         an_log     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;

         if (step) begin
            psc <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else if (en) begin
            psc <= psc + 1'b1;
         end

         // A load landing on the wrap cycle goes straight to the display,
         // superseding whatever was still pending.
         if (boundary) begin
            if (load) begin
               act_num <= num;
               act_dp  <= dp;
               act_lz  <= lz_blank;
            end else if (pnd_valid) begin
               act_num <= pnd_num;
               act_dp  <= pnd_dp;
               act_lz  <= pnd_lz;
            end
            pnd_valid <= 1'b0;
         end else if (load) begin
            pnd_num   <= num;
            pnd_dp    <= dp;
            pnd_lz    <= lz_blank;
            pnd_valid <= 1'b1;
         end

         if (en) begin
            an_log  <= DIGITS'(1) << idx;
            seg_log <= {cur_dp, suppress ? 7'h00 : hex7(cur_nib)};
         end else begin
            an_log  <= '0;
            seg_log <= '0;
         end
      end
   end

   assign o_seg = seg_log ^ {8{ACTIVE_LOW}};
   assign o_an  = an_log ^ {DIGITS{ACTIVE_LOW}};

endmodule
